booth4_ctrl: RTL and testbench

//  Control FSM for the 8-bit radix-4 Booth multiplier datapath; sits directly upstream of it.

---
 rtl/booth4_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_booth4_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/booth4_ctrl.sv
// Control FSM for the 8-bit radix-4 Booth multiplier datapath.
// Optional build macro BOOTH4_SKIP_ZERO_EN: TEST bypasses ADD for 000/111 triplets.

module booth4_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit0,
    input  logic bit1,
    input  logic bit2,
    input  logic eqcount,
    output logic ldmp,
    output logic ldmplier,
    output logic ldprd,
    output logic funcsel,
    output logic muxsel,
    output logic shr,
    output logic inc_count,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ADD  = 3'd2,
        S_SH1  = 3'd3,
        S_SH2  = 3'd4,
        S_TEST = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      state_r;
    state_t      fsm_next_s;
    state_t      next_s;
    logic [7:0]  wdog_r;
    logic        err_r;
    logic        ldmp_r;
    logic        ldmplier_r;
    logic        shr_r;
    logic        inc_count_r;
    logic        busy_r;
    logic        done_r;
    logic        ldprd_s;
    logic        funcsel_s;
    logic        muxsel_s;
    logic        timeout_s;
    logic [2:0]  trip_s;

    assign trip_s = {bit2, bit1, bit0};

`ifdef BOOTH4_SKIP_ZERO_EN
    logic zero_trip_s;
    assign zero_trip_s = (trip_s == 3'b000) || (trip_s == 3'b111);
`endif

    // The watchdog is not armed in DONE, so a completed run can never also flag a timeout.
    assign timeout_s = (state_r != S_IDLE) && (state_r != S_DONE) &&
                       (wdog_r == 8'(TIMEOUT - 1));

    // Next-state sequencing of the Booth iteration loop.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    fsm_next_s = S_LOAD;
                end else begin
                    fsm_next_s = S_IDLE;
                end
            end
            S_LOAD: fsm_next_s = S_ADD;
            S_ADD:  fsm_next_s = S_SH1;
            S_SH1:  fsm_next_s = S_SH2;
            S_SH2:  fsm_next_s = S_TEST;
            S_TEST: begin
                if (eqcount) begin
                    fsm_next_s = S_DONE;
`ifdef BOOTH4_SKIP_ZERO_EN
                end else if (zero_trip_s) begin
                    fsm_next_s = S_SH1;
`endif
                end else begin
                    fsm_next_s = S_ADD;
                end
            end
            S_DONE: fsm_next_s = S_IDLE;
            default: fsm_next_s = S_IDLE;
        endcase
        next_s = timeout_s ? S_IDLE : fsm_next_s;
    end

    // Booth triplet decode; only this part of the output set follows the inputs directly.
    always_comb begin
        ldprd_s   = 1'b0;
        funcsel_s = 1'b0;
        muxsel_s  = 1'b0;
        if (state_r == S_ADD) begin
            case (trip_s)
                3'b001, 3'b010: begin ldprd_s = 1'b1; funcsel_s = 1'b1; muxsel_s = 1'b0; end
                3'b011:         begin ldprd_s = 1'b1; funcsel_s = 1'b1; muxsel_s = 1'b1; end
                3'b100:         begin ldprd_s = 1'b1; funcsel_s = 1'b0; muxsel_s = 1'b1; end
                3'b101, 3'b110: begin ldprd_s = 1'b1; funcsel_s = 1'b0; muxsel_s = 1'b0; end
                default:        begin ldprd_s = 1'b0; funcsel_s = 1'b1; muxsel_s = 1'b0; end
            endcase
        end else begin
            ldprd_s   = 1'b0;
            funcsel_s = 1'b0;
            muxsel_s  = 1'b0;
        end
    end

    // State, watchdog, sticky error and next-state-decoded Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wdog_r      <= 8'd0;
            err_r       <= 1'b0;
            ldmp_r      <= 1'b0;
            ldmplier_r  <= 1'b0;
            shr_r       <= 1'b0;
            inc_count_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= next_s;
            if (state_r == S_IDLE) begin
                wdog_r <= 8'd0;
            end else begin
                wdog_r <= wdog_r + 8'd1;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else if ((state_r == S_IDLE) && start) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            ldmp_r      <= (next_s == S_LOAD);
            ldmplier_r  <= (next_s == S_LOAD);
            shr_r       <= (next_s == S_SH1) || (next_s == S_SH2);
            inc_count_r <= (next_s == S_SH2);
            busy_r      <= (next_s != S_IDLE);
            done_r      <= (next_s == S_DONE);
        end
    end

    assign ldmp      = ldmp_r;
    assign ldmplier  = ldmplier_r;
    assign ldprd     = ldprd_s;
    assign funcsel   = funcsel_s;
    assign muxsel    = muxsel_s;
    assign shr       = shr_r;
    assign inc_count = inc_count_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

    booth4_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .ldprd    (ldprd_s),
        .shr      (shr_r),
        .ldmplier (ldmplier_r),
        .done     (done_r),
        .busy     (busy_r)
    );

endmodule

module booth4_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic ldprd,
    input logic shr,
    input logic ldmplier,
    input logic done,
    input logic busy
);

    a_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({ldprd, shr, ldmplier}));

    a_done_busy: assert property (@(posedge clk) disable iff (rst)
        done |-> busy);

endmodule

// File: tb/tb_booth4_ctrl.sv
// Directed bench for booth4_ctrl with a behavioural radix-4 Booth datapath in the loop.
// Honours BOOTH4_SKIP_ZERO_EN for expected latency and ADD visits.

module tb_booth4_ctrl;

    logic clk = 1'b0;
    logic rst, start, bit0, bit1, bit2, eqcount;
    logic ldmp, ldmplier, ldprd, funcsel, muxsel, shr, inc_count, busy, done, err;

    always #5 clk = ~clk;

    booth4_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .bit0(bit0), .bit1(bit1), .bit2(bit2),
        .eqcount(eqcount), .ldmp(ldmp), .ldmplier(ldmplier), .ldprd(ldprd),
        .funcsel(funcsel), .muxsel(muxsel), .shr(shr), .inc_count(inc_count),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural datapath: 10-bit accumulator keeps +/-2M sums from overflowing.
    logic [7:0] mcand, mplier;
    logic       tie_eq;
    logic [9:0] dp_a;
    logic [7:0] dp_q, dp_m;
    logic       dp_q1;
    logic [2:0] dp_cnt;
    logic [9:0] addend;

    assign addend  = muxsel ? {dp_m[7], dp_m, 1'b0} : {{2{dp_m[7]}}, dp_m};
    assign bit0    = dp_q1;
    assign bit1    = dp_q[0];
    assign bit2    = dp_q[1];
    assign eqcount = !tie_eq && (dp_cnt == 3'd4);

    always @(posedge clk) begin
        if (ldmp) dp_m <= mcand;
        if (ldmplier) begin
            dp_a <= 10'd0; dp_q <= mplier; dp_q1 <= 1'b0; dp_cnt <= 3'd0;
        end else begin
            if (ldprd) dp_a <= funcsel ? dp_a + addend : dp_a - addend;
            if (shr) begin
                dp_a  <= {dp_a[9], dp_a[9:1]};
                dp_q  <= {dp_a[0], dp_q[7:1]};
                dp_q1 <= dp_q[0];
            end
            if (inc_count) dp_cnt <= dp_cnt + 3'd1;
        end
    end

    wire [15:0] product = {dp_a[7:0], dp_q};
    wire [9:0]  outs = {ldmp, ldmplier, ldprd, funcsel, muxsel, shr, inc_count, busy, done, err};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-run trace (index = clock cycle after the accept edge, 1 = LOAD).
    logic        tr_done [0:63];
    logic        tr_busy [0:63];
    logic        tr_err  [0:63];
    logic        tr_ldmp [0:63];
    logic [11:0] ops;
    int          n_add, n_done, n_excl, done_cyc;

    task automatic trace(input logic [7:0] mc, input logic [7:0] mp,
                         input int hold_cycles, input int ncyc);
        mcand = mc; mplier = mp;
        ops = 12'd0; n_add = 0; n_done = 0; n_excl = 0; done_cyc = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > hold_cycles) start = 1'b0;
            tr_done[c] = done; tr_busy[c] = busy; tr_err[c] = err; tr_ldmp[c] = ldmp;
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy && (ldprd || funcsel)) begin
                ops = {ops[8:0], ldprd, funcsel, muxsel};
                n_add++;
            end
            if ($countones({ldprd, shr, ldmplier}) > 1) n_excl++;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Skipped ADDs: zero triplets in iterations 2..4 when the skip feature is built in.
    function automatic int exp_skips(input logic [7:0] mp);
        int s;
        logic [2:0] t;
        s = 0;
`ifdef BOOTH4_SKIP_ZERO_EN
        for (int i = 1; i < 4; i++) begin
            t = {mp[2*i+1], mp[2*i], mp[2*i-1]};
            if (t == 3'b000 || t == 3'b111) s++;
        end
`endif
        return s;
    endfunction

    // ops codes per ADD {ldprd,funcsel,muxsel}: +M 110, +2M 111, -2M 101, -M 100, zero 010
    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        logic [15:0] prod;
        logic [11:0] ops;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'h03, 8'h05, 16'h000F, {3'b110, 3'b110, 3'b010, 3'b010}};
        vecs[1] = '{8'hF9, 8'h06, 16'hFFD6, {3'b101, 3'b111, 3'b010, 3'b010}};
        vecs[2] = '{8'h7F, 8'h80, 16'hC080, {3'b010, 3'b010, 3'b010, 3'b101}};
        vecs[3] = '{8'h05, 8'hFF, 16'hFFFB, {3'b100, 3'b010, 3'b010, 3'b010}};
        vecs[4] = '{8'h02, 8'h55, 16'h00AA, {3'b110, 3'b110, 3'b110, 3'b110}};
        vecs[5] = '{8'h80, 8'h80, 16'h4000, {3'b010, 3'b010, 3'b010, 3'b101}};

        rst = 1'b1; start = 1'b0; tie_eq = 1'b0; mcand = 8'd0; mplier = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {6'd0, outs}, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", {6'd0, outs}, 16'd0);

        for (int v = 0; v < 6; v++) begin
            int lat;
            lat = 18 - exp_skips(vecs[v].mp);
            trace(vecs[v].mc, vecs[v].mp, 0, 24);
            chk($sformatf("v%0d_load", v), {13'd0, tr_ldmp[1], tr_busy[1], tr_busy[19]}, 16'd6);
            chk($sformatf("v%0d_latency", v), 16'(done_cyc), 16'(lat));
            chk($sformatf("v%0d_done_count", v), 16'(n_done), 16'd1);
            chk($sformatf("v%0d_product", v), product, vecs[v].prod);
            chk($sformatf("v%0d_excl", v), 16'(n_excl), 16'd0);
`ifdef BOOTH4_SKIP_ZERO_EN
            chk($sformatf("v%0d_add_visits", v), 16'(n_add), 16'(4 - exp_skips(vecs[v].mp)));
`else
            chk($sformatf("v%0d_ops", v), {4'd0, ops}, {4'd0, vecs[v].ops});
`endif
        end

        // Watchdog: eqcount never asserts, 32 busy cycles then abort.
        tie_eq = 1'b1;
        trace(8'h03, 8'h05, 0, 40);
        chk("to_busy32", {15'd0, tr_busy[32]}, 16'd1);
        chk("to_err32", {15'd0, tr_err[32]}, 16'd0);
        chk("to_err33", {15'd0, tr_err[33]}, 16'd1);
        chk("to_busy33", {15'd0, tr_busy[33]}, 16'd0);
        chk("to_err_sticky", {15'd0, tr_err[40]}, 16'd1);
        chk("to_no_done", 16'(n_done), 16'd0);
        tie_eq = 1'b0;
        trace(8'h03, 8'h05, 0, 24);
        chk("err_cleared", {15'd0, tr_err[1]}, 16'd0);
        chk("after_to_product", product, 16'h000F);

        // start held through DONE: one IDLE cycle, then a second run.
        trace(8'h03, 8'h05, 19, 44);
        chk("hold_done1", {15'd0, tr_done[18 - exp_skips(8'h05)]}, 16'd1);
        chk("hold_idle19", {15'd0, tr_busy[19]}, 16'd0);
        chk("hold_load20", {14'd0, tr_busy[20], tr_ldmp[20]}, 16'd3);
        chk("hold_done_count", 16'(n_done), 16'd2);
        chk("hold_product", product, 16'h000F);

        // Reset during SH1 aborts immediately and never produces done.
        begin
            int found, ndone;
            found = 0; ndone = 0;
            mcand = 8'hF9; mplier = 8'h06;
            @(negedge clk); start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            for (int c = 0; c < 10 && found == 0; c++) begin
                if (shr) found = 1;
                else begin @(posedge clk); #1; end
            end
            chk("sh1_reached", 16'(found), 16'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_sh1_outs", {6'd0, outs}, 16'd0);
            rst = 1'b0;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk); #1;
                if (done) ndone++;
            end
            chk("rst_sh1_no_done", 16'(ndone), 16'd0);
            chk("rst_sh1_idle", {15'd0, busy}, 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not complete in time");
        $fatal(1);
    end

endmodule
